kbd_mmio: RTL and testbench
===========================

# kbd_mmio

Memory-mapped PS/2 keyboard input port for the riscv_core system; it is the input-side counterpart of the VGA terminal output path. It receives PS/2 frames from the keyboard, checks them, buffers the scan-code bytes in a FIFO, and lets the core poll and pop them through the shared data-memory bus. The top level decodes the window 0xa1000000–0xa100000f and drives `ena`. Read data is returned with the same one-cycle registered latency as the RAM.

## Interface
- `FIFO_DEPTH`, 16: scan-code FIFO entries; must be a power of 2.
- `FILTER_LEN`, 8: number of consecutive equal samples required before the synchronized `ps2_clk` level is accepted.
- `TIMEOUT`, 50000: clock cycles with no `ps2_clk` falling edge, while mid-frame, before the receiver aborts the frame (1 ms at 50 MHz).
- `clk`, input, 1: system clock (CLOCK_50). One clock domain only.
- `rst`, input, 1: synchronous, active-high reset.
- `ps2_clk`, input, 1: PS/2 clock line; asynchronous to `clk`.
- `ps2_dat`, input, 1: PS/2 data line; asynchronous to `clk`.
- `ena`, input, 1: the bus access targets this block (address decoded by the top level).
- `mem_rw`, input, 1: `MEM_READ` or `MEM_WRITE`.
- `mem_addr`, input, `DATA_BUS`: byte address; only bits [3:2] are used.
- `mem_wdata`, input, `DATA_BUS`: write data.
- `mem_rdata`, output, `DATA_BUS`: registered read data; resets to 0.
- `kbd_nonempty`, output, 1: FIFO holds at least one byte (intended for an LED); resets to 0.

## Operation
- Input conditioning:
  - Both PS/2 lines pass through a 2-FF synchronizer.
  - The `ps2_clk` level changes only after `FILTER_LEN` equal samples.
  - A falling edge of the filtered clock produces a one-cycle `fall` strobe.
- Receiver FSM, sampling `ps2_dat` on `fall`:
  - IDLE: a sampled 0 (start bit) moves to DATA and clears the bit counter. A sampled 1 stays in IDLE.
  - DATA: shift in 8 bits, LSB first; after the 8th bit move to PARITY.
  - PARITY: latch the parity bit; move to STOP.
  - STOP: if the stop bit is 1 and the data bits plus parity have odd parity, push the byte. Otherwise set sticky `ERR`. Always return to IDLE.
  - Timeout: in any state other than IDLE, `TIMEOUT` cycles with no `fall` force IDLE and set `ERR`. The timer restarts on every `fall`.
- FIFO:
  - Synchronous, with `FIFO_DEPTH` entries and a count of width log2(`FIFO_DEPTH`)+1.
  - Push when full: the byte is dropped and sticky `OVF` is set.
  - Push and pop in the same cycle: allowed even when full or empty. When empty, the pop sees empty and does nothing; the push still succeeds.
- Register map (word offset = `mem_addr[3:2]`):
  - 0 STATUS (read-only):
    - bit0 = nonempty, bit1 = `OVF`, bit2 = `ERR`.
    - bits[15:8] = count, zero-extended.
    - Reading STATUS clears `OVF` and `ERR` after their values are captured into `mem_rdata`.
  - 1 DATA:
    - Read returns {24'b0, head byte} and pops the FIFO.
    - Read when empty returns 0 and does not pop.
  - 2 CTRL:
    - Write with `mem_wdata[0]` = 1 flushes the FIFO; writes are otherwise ignored.
    - Reads as 0.
  - 3: reads 0; writes are ignored.
- Pop and status-clear side effects fire only on the first cycle of a contiguous read. The block registers the previous cycle's `ena & read & offset` and compares against it, so a core that holds the address for several cycles pops exactly one byte.
- Side effects are suppressed when `ena` = 0; `mem_rdata` is then 0.

## Timing
- Read latency is 1 cycle: data for a request presented in cycle N appears in `mem_rdata` after the clock edge ending cycle N. The same edge updates the FIFO read pointer.
- `ps2_dat` sampling: `fall` is asserted 2 + `FILTER_LEN` cycles after the pin edge; the data line goes through the same 2-FF delay.
- The byte becomes visible in STATUS/count one cycle after the `fall` that samples the stop bit.
- `kbd_nonempty` is registered and tracks count with one cycle of delay.
- Reset, including mid-frame: the FSM goes to IDLE, the FIFO is emptied, `OVF`/`ERR` clear, filters reset to 1 (line idle), and the timer clears.
- A CTRL flush in the same cycle as a push: the flush wins and the byte is lost.

## Structure
- Shared definitions go in common.v:
  - `KBD_BASE` = 32'ha1000000
  - `KBD_STATUS`, `KBD_DATA`, `KBD_CTRL` offsets
  - status bit indices
- Sub-module `ps2_rx` contains the synchronizer, filter, FSM and timeout. It outputs `byte_valid` (1 cycle), `byte_data[7:0]` and `frame_err` (1 cycle).
- `kbd_mmio` contains the FIFO, register decode, edge-qualified pop and sticky flags.

## Test plan
- Send frame 0x1C (start 0, LSB-first data, parity 0, stop 1) at 12.5 kHz -> STATUS = 0x0101; DATA read returns 0x1C; next STATUS = 0x0000.
- Send the same frame with the parity bit flipped -> FIFO stays empty; STATUS = 0x0004; a second STATUS read returns 0x0000.
- Send 17 frames, 0x01 through 0x11 -> count = 16 and `OVF` set; 16 DATA reads return 0x01…0x10 in order; a 17th read returns 0.
- Hold a DATA read for 5 consecutive cycles with 3 bytes queued -> exactly one pop; count goes 3 -> 2.
- Stop `ps2_clk` after 4 data bits -> after 50000 cycles, `ERR` is set and the FSM is in IDLE; a following full frame 0x5A is received correctly.
- Assert `rst` for 1 cycle mid-frame with 2 bytes queued -> count = 0, `mem_rdata` = 0, `kbd_nonempty` = 0; the next full frame is received normally.

Source files
------------

// File: rtl/kbd_mmio_pkg.sv
// Shared definitions for the PS/2 keyboard MMIO port: bus window, register
// offsets, status bit positions and receiver state encoding.
package kbd_mmio_pkg;

    localparam int DATA_BUS = 32;

    localparam logic [31:0] KBD_BASE = 32'ha1000000;

    // Word offsets within the window (mem_addr[3:2])
    localparam logic [1:0] KBD_STATUS = 2'd0;
    localparam logic [1:0] KBD_DATA   = 2'd1;
    localparam logic [1:0] KBD_CTRL   = 2'd2;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // STATUS register bit positions
    localparam int ST_NONEMPTY  = 0;
    localparam int ST_OVF       = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // A frame is good when the stop bit is high and data plus parity hold an odd number of ones
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^{data, par});
    endfunction

endpackage

// File: rtl/kbd_mmio_ps2_rx.sv
// PS/2 receiver: line synchronizers, clock glitch filter, frame FSM and
// mid-frame timeout. Emits one-cycle byte_valid / frame_err strobes.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   RX_IDLE   | waiting for a start bit (data low on a fall)
//   RX_DATA   | shifting in 8 data bits, LSB first
//   RX_PARITY | latching the odd-parity bit
//   RX_STOP   | checking stop bit and parity, then back to idle
module kbd_mmio_ps2_rx
    import kbd_mmio_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [FLT_W-1:0] FLT_RELOAD = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT - 1);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_flt;
    logic             clk_flt_d;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;
    logic             dat_s;

    rx_state_t        state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             par_bit;
    logic [TMR_W-1:0] timer;

    assign dat_s = dat_sync[1];
    assign fall  = clk_flt_d & ~clk_flt;

    // Two-flop synchronizers; both lines idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    // Accept a new ps2_clk level only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_flt   <= 1'b1;
            clk_flt_d <= 1'b1;
            flt_cnt   <= FLT_RELOAD;
        end else begin
            clk_flt_d <= clk_flt;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= FLT_RELOAD;
            end else if (flt_cnt == '0) begin
                clk_flt <= clk_sync[1];
                flt_cnt <= FLT_RELOAD;
            end else begin
                flt_cnt <= flt_cnt - FLT_W'(1);
            end
        end
    end

    // Frame FSM with timeout down-counter reloaded on every filtered falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (fall) begin
                timer <= TMR_RELOAD;
            end else if (timer != '0) begin
                timer <= timer - TMR_W'(1);
            end

            if ((state != RX_IDLE) && !fall && (timer == '0)) begin
                state     <= RX_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!dat_s) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {dat_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        par_bit <= dat_s;
                        state   <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (frame_ok(shift, par_bit, dat_s)) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/kbd_mmio.sv
// Memory-mapped PS/2 keyboard port: scan-code FIFO, register decode,
// first-cycle-qualified pop/clear side effects and sticky OVF/ERR flags.
module kbd_mmio
    import kbd_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_dat,
    input  logic                ena,
    input  logic                mem_rw,
    input  logic [DATA_BUS-1:0] mem_addr,
    input  logic [DATA_BUS-1:0] mem_wdata,
    output logic [DATA_BUS-1:0] mem_rdata,
    output logic                kbd_nonempty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             frame_err;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [1:0]       offset;
    logic             rd_req;
    logic             wr_req;
    logic             rd_prev;
    logic [1:0]       off_prev;
    logic             rd_first;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             stat_clr;
    logic             flush;
    logic             push_ok;
    logic             push_drop;
    logic             ovf;
    logic             err;
    logic [DATA_BUS-1:0] status_word;
    logic             unused_bus;

    kbd_mmio_ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign offset     = mem_addr[3:2];
    assign rd_req     = ena & (mem_rw == MEM_READ);
    assign wr_req     = ena & (mem_rw == MEM_WRITE);
    // A read held at the same offset only has side effects on its first cycle
    assign rd_first   = rd_req & ~(rd_prev & (off_prev == offset));
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = rd_first & (offset == KBD_DATA) & ~fifo_empty;
    assign stat_clr   = rd_first & (offset == KBD_STATUS);
    assign flush      = wr_req & (offset == KBD_CTRL) & mem_wdata[0];
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push_ok    = byte_valid & (~fifo_full | pop);
    assign push_drop  = byte_valid & fifo_full & ~pop & ~flush;

    assign unused_bus = ^{mem_addr[DATA_BUS-1:4], mem_addr[1:0], mem_wdata[DATA_BUS-1:1]};

    // Pack the STATUS word from live FIFO state and sticky flags
    always_comb begin
        status_word                             = '0;
        status_word[ST_NONEMPTY]                = ~fifo_empty;
        status_word[ST_OVF]                     = ovf;
        status_word[ST_ERR]                     = err;
        status_word[ST_COUNT_LSB +: 8]          = 8'(count);
    end

    // FIFO pointers and occupancy; flush overrides any push in the same cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            fifo_mem[wr_ptr] <= byte_data;
        end
    end

    // Sticky flags: a new event in the clearing cycle was not yet reported, so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            if (stat_clr) begin
                ovf <= 1'b0;
                err <= 1'b0;
            end
            if (push_drop) begin
                ovf <= 1'b1;
            end
            if (frame_err) begin
                err <= 1'b1;
            end
        end
    end

    // Previous-cycle read request, for first-cycle detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_prev  <= 1'b0;
            off_prev <= '0;
        end else begin
            rd_prev  <= rd_req;
            off_prev <= offset;
        end
    end

    // Registered read data and LED output
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata    <= '0;
            kbd_nonempty <= 1'b0;
        end else begin
            kbd_nonempty <= ~fifo_empty;
            mem_rdata    <= '0;
            if (rd_req) begin
                case (offset)
                    KBD_STATUS: mem_rdata <= status_word;
                    KBD_DATA: begin
                        if (!fifo_empty) begin
                            mem_rdata <= {{(DATA_BUS-8){1'b0}}, fifo_mem[rd_ptr]};
                        end
                    end
                    default: mem_rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kbd_mmio.sv
// Self-checking bench for kbd_mmio: PS/2 frame generator, bus read/write
// tasks and a scoreboard queue of bytes expected back from DATA reads.
module tb_kbd_mmio;
    import kbd_mmio_pkg::*;

    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_dat;
    logic        ena;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        kbd_nonempty;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_q[$];
    logic       m_ovf;
    logic       m_err;

    always #5 clk = ~clk;

    kbd_mmio #(
        .FIFO_DEPTH (16),
        .FILTER_LEN (8),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .ena          (ena),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .kbd_nonempty (kbd_nonempty)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    // Full frame; the scoreboard learns what the FIFO should now hold
    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        wait_clk(HALF);
        if (bad_par) m_err = 1'b1;
        else if (sb_q.size() < 16) sb_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [31:0] d);
        @(negedge clk);
        ena      = 1'b1;
        mem_rw   = MEM_READ;
        mem_addr = KBD_BASE | {28'h0, off, 2'b00};
        @(posedge clk);
        #1 d = mem_rdata;
        @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] wd);
        @(negedge clk);
        ena       = 1'b1;
        mem_rw    = MEM_WRITE;
        mem_addr  = KBD_BASE | {28'h0, off, 2'b00};
        mem_wdata = wd;
        @(negedge clk);
        ena       = 1'b0;
        mem_rw    = MEM_READ;
        mem_wdata = '0;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s       = '0;
        s[15:8] = 8'(sb_q.size());
        s[0]    = (sb_q.size() != 0);
        s[1]    = m_ovf;
        s[2]    = m_err;
        return s;
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        wait_clk(3);
        checks++;
        if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", mem_rdata); end
        checks++;
        if (kbd_nonempty !== 1'b0) begin errors++; $display("FAIL reset_nonempty: got %b want 0", kbd_nonempty); end
        rst = 1'b0;
        wait_clk(2);
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", d); end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        logic [31:0] e;
        send_frame(8'h1C, 1'b0);
        checks++;
        if (kbd_nonempty !== 1'b1) begin errors++; $display("FAIL single_led: got %b want 1", kbd_nonempty); end
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0101) begin errors++; $display("FAIL single_status: got %h want 00000101", d); end
        bus_read(KBD_DATA, d);
        e = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
        checks++;
        if (d !== e) begin errors++; $display("FAIL single_data: got %h want %h", d, e); end
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL single_status2: got %h want 0", d); end
    endtask

    task automatic test_parity_err();
        logic [31:0] d;
        send_frame(8'h1C, 1'b1);
        checks++;
        if (kbd_nonempty !== 1'b0) begin errors++; $display("FAIL parity_led: got %b want 0", kbd_nonempty); end
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0004) begin errors++; $display("FAIL parity_status: got %h want 00000004", d); end
        m_err = 1'b0;
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL parity_status2: got %h want 0", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] e;
        for (int v = 1; v <= 17; v++) send_frame(8'(v), 1'b0);
        bus_read(KBD_STATUS, d);
        e = exp_status();
        checks++;
        if (d !== e || d !== 32'h1003) begin errors++; $display("FAIL ovf_status: got %h want %h", d, e); end
        m_ovf = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus_read(KBD_DATA, d);
            e = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
            checks++;
            if (d !== e) begin errors++; $display("FAIL ovf_data[%0d]: got %h want %h", i, d, e); end
        end
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ovf_status2: got %h want 0", d); end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic [31:0] e;
        send_frame(8'h21, 1'b0);
        send_frame(8'h22, 1'b0);
        bus_read(KBD_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h want 0", d); end
        bus_read(2'd3, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL off3_read: got %h want 0", d); end
        bus_write(KBD_CTRL, 32'h0000_0002);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(KBD_STATUS, d);
        e = exp_status();
        checks++;
        if (d !== e) begin errors++; $display("FAIL flush_noop: got %h want %h", d, e); end
        bus_write(KBD_CTRL, 32'h0000_0001);
        sb_q.delete();
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL flush_status: got %h want 0", d); end
        bus_read(KBD_DATA, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL flush_data: got %h want 0", d); end
    endtask

    task automatic test_held_read();
        logic [31:0] d;
        logic [31:0] first;
        logic [31:0] e;
        send_frame(8'hA1, 1'b0);
        send_frame(8'hB2, 1'b0);
        send_frame(8'hC3, 1'b0);
        @(negedge clk);
        ena      = 1'b1;
        mem_rw   = MEM_READ;
        mem_addr = KBD_BASE | 32'h4;
        @(posedge clk);
        #1 first = mem_rdata;
        repeat (4) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        e = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
        checks++;
        if (first !== e) begin errors++; $display("FAIL held_data: got %h want %h", first, e); end
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0201) begin errors++; $display("FAIL held_status: got %h want 00000201", d); end
        for (int i = 0; i < 2; i++) begin
            bus_read(KBD_DATA, d);
            e = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
            checks++;
            if (d !== e) begin errors++; $display("FAIL held_drain[%0d]: got %h want %h", i, d, e); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic [31:0] e;
        send_partial(8'hFF, 4);
        wait_clk(TMO - 200);
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL tmo_early: got %h want 0", d); end
        wait_clk(400);
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0004) begin errors++; $display("FAIL tmo_err: got %h want 00000004", d); end
        send_frame(8'h5A, 1'b0);
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0101) begin errors++; $display("FAIL tmo_status: got %h want 00000101", d); end
        bus_read(KBD_DATA, d);
        e = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
        checks++;
        if (d !== e || d !== 32'h5A) begin errors++; $display("FAIL tmo_data: got %h want %h", d, e); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [31:0] e;
        send_frame(8'h11, 1'b0);
        send_frame(8'h22, 1'b0);
        send_partial(8'h33, 3);
        @(negedge clk);
        ena      = 1'b1;
        mem_rw   = MEM_READ;
        mem_addr = KBD_BASE;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b0;
        ps2_dat = 1'b1;
        sb_q.delete();
        checks++;
        if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h want 0", mem_rdata); end
        checks++;
        if (kbd_nonempty !== 1'b0) begin errors++; $display("FAIL rstmid_led: got %b want 0", kbd_nonempty); end
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rstmid_status: got %h want 0", d); end
        wait_clk(HALF);
        send_frame(8'h44, 1'b0);
        bus_read(KBD_STATUS, d);
        checks++;
        if (d !== 32'h0101) begin errors++; $display("FAIL rstmid_status2: got %h want 00000101", d); end
        bus_read(KBD_DATA, d);
        e = (sb_q.size() != 0) ? {24'h0, sb_q.pop_front()} : 32'h0;
        checks++;
        if (d !== e || d !== 32'h44) begin errors++; $display("FAIL rstmid_data: got %h want %h", d, e); end
    endtask

    initial begin
        rst       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        ena       = 1'b0;
        mem_rw    = MEM_READ;
        mem_addr  = '0;
        mem_wdata = '0;
        m_ovf     = 1'b0;
        m_err     = 1'b0;
        test_reset();
        test_single_frame();
        test_parity_err();
        test_overflow();
        test_flush();
        test_held_read();
        test_timeout();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

endmodule
